// File: rtl/config_tile_framed.sv
// config_tile_framed
//   Fabric configuration tile. A shadow shift chain collects one frame of
//   {[parity], input_mux, mem_ctrl, comb_config, mem_config} (MSB -> LSB).
//   A set request commits the shadow to the active registers only when the
//   whole frame has been shifted in (and, with parity enabled, it has even
//   parity). shift_out is the chain tail for the next tile in the column.
//
//   Optional feature macro: CONFIG_PARITY_EN
//     defined   : frame carries one extra MSB parity bit; frames with odd
//                 parity are rejected with cfg_error.
//     undefined : no parity bit; every complete frame is accepted.
//
//   Set / pulse protocol: set (from the source chosen by the active
//   input_mux) is a level sampled at each clock edge. An accepted set
//   commits at that edge and comb_set (plus mem_set when the new mem_ctrl
//   is 0) is high for exactly the following cycle. A rejected set raises the
//   sticky cfg_error and produces no pulse. Either way the frame counter
//   restarts, and any shift requested in the same cycle is dropped.
//
//   state_dbg exposes the frame FSM: 0 = IDLE, 1 = LOADING, 2 = FULL.

module config_tile_framed #(
   parameter int COMB_N = 7,
   parameter int MEM_N  = 7,
   parameter int SLICES = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       shift_enable,
   input  logic                       shift_in_hard,
   input  logic                       shift_in_soft,
   input  logic                       set_hard,
   input  logic                       set_soft,
   output logic                       shift_out,
   output logic [SLICES*COMB_N-1:0]   comb_config,
   output logic [SLICES*MEM_N-1:0]    mem_config,
   output logic                       comb_set,
   output logic                       mem_set,
   output logic                       cfg_valid,
   output logic                       cfg_error,
   output logic [1:0]                 state_dbg
);

   localparam int COMB_W   = SLICES * COMB_N;
   localparam int MEM_W    = SLICES * MEM_N;
   localparam int CFG_BITS = COMB_W + MEM_W;
`ifdef CONFIG_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif
   localparam int FRAME_BITS = 2 + CFG_BITS + PAR_BITS;
   localparam int CTRL_IDX   = CFG_BITS;       // mem_ctrl position in frame
   localparam int MUX_IDX    = CFG_BITS + 1;   // input_mux position in frame
   localparam int CNT_W      = $clog2(FRAME_BITS + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOADING = 2'd1,
      ST_FULL    = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [FRAME_BITS-1:0]   shadow;
   logic [CNT_W-1:0]        cnt;
   logic [CNT_W-1:0]        cnt_next;
   logic                    input_mux;
   logic                    mem_ctrl;

   logic                    shift_in_sel;
   logic                    set_sel;
   logic                    shift_do;
   logic                    frame_good;
   logic                    commit;
   logic                    reject;

   // Source selection and commit decision for this cycle.
   always_comb begin
      shift_in_sel = input_mux ? shift_in_soft : shift_in_hard;
      set_sel      = input_mux ? set_soft : set_hard;
`ifdef CONFIG_PARITY_EN
      frame_good   = ~(^shadow);
`else
      frame_good   = 1'b1;
`endif
      // A set in the same cycle wins over the shift.
      shift_do     = shift_enable & ~set_sel;
      commit       = set_sel & (state == ST_FULL) & frame_good;
      reject       = set_sel & ~commit;
   end

   // Frame FSM and bit counter: next-state logic.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      if (shift_do && (cnt != CNT_FULL)) begin
         cnt_next = cnt + 1'b1;
      end
      case (state)
         ST_IDLE: begin
            if (shift_do) state_next = ST_LOADING;
         end
         ST_LOADING: begin
            if (shift_do && (cnt == CNT_LAST)) state_next = ST_FULL;
         end
         ST_FULL: begin
            state_next = ST_FULL;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
      // Any set, accepted or not, restarts frame collection.
      if (set_sel) begin
         state_next = ST_IDLE;
         cnt_next   = '0;
      end
   end

   // Frame FSM and bit counter: state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Shadow chain: first bit shifted ends at the MSB; keeps shifting when
   // the frame is full so upstream frames pass through to the next tile.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow <= '0;
      end else if (shift_do) begin
         shadow <= {shadow[FRAME_BITS-2:0], shift_in_sel};
      end
   end

   // Active configuration: loads on commit; mem bits only when the new
   // mem_ctrl is 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         comb_config <= '0;
         mem_config  <= '0;
         mem_ctrl    <= 1'b0;
         input_mux   <= 1'b0;
      end else if (commit) begin
         comb_config <= shadow[MEM_W +: COMB_W];
         mem_ctrl    <= shadow[CTRL_IDX];
         input_mux   <= shadow[MUX_IDX];
         if (!shadow[CTRL_IDX]) begin
            mem_config <= shadow[MEM_W-1:0];
         end
      end
   end

   // Status flags and the one-cycle commit pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         comb_set  <= 1'b0;
         cfg_valid <= 1'b0;
         cfg_error <= 1'b0;
      end else begin
         comb_set <= commit;
         if (commit) begin
            cfg_valid <= 1'b1;
            cfg_error <= 1'b0;
         end else if (reject) begin
            cfg_error <= 1'b1;
         end
      end
   end

   // mem_ctrl already holds the newly committed value while comb_set is
   // high, so the mem pulse is the comb pulse qualified by it.
   always_comb begin
      mem_set   = comb_set & ~mem_ctrl;
      shift_out = shadow[FRAME_BITS-1];
      state_dbg = state;
   end

endmodule
